// File: rtl/systolic_feeder_if.sv
// Bus between the systolic feeder and its surroundings: the element load
// handshake on one side, the skewed row/column streams and control towards
// the 3x3 processing-element array on the other.
interface systolic_feeder_if #(
  parameter int unsigned DATA_SIZE = 8
) ();

  logic                 in_valid;
  logic [DATA_SIZE-1:0] in_data;
  logic                 in_ready;

  logic [DATA_SIZE-1:0] a1;
  logic [DATA_SIZE-1:0] a2;
  logic [DATA_SIZE-1:0] a3;
  logic [DATA_SIZE-1:0] b1;
  logic [DATA_SIZE-1:0] b2;
  logic [DATA_SIZE-1:0] b3;

  logic                 pe_clr;
  logic                 busy;
  logic                 done;

  // Producer of matrix elements and consumer of the streams
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  a1,
    input  a2,
    input  a3,
    input  b1,
    input  b2,
    input  b3,
    input  pe_clr,
    input  busy,
    input  done
  );

  // The feeder itself
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output a1,
    output a2,
    output a3,
    output b1,
    output b2,
    output b3,
    output pe_clr,
    output busy,
    output done
  );

endinterface

// File: rtl/systolic_feeder.sv
// Systolic feeder for a 3x3 output-stationary matrix multiply array.
// Collects A then B (row-major, 18 elements), clears the array accumulators,
// streams skewed rows of A into the left edge and columns of B into the top
// edge over 5 cycles, waits 2 cycles for the far corner, then pulses done.
module systolic_feeder #(
  parameter int unsigned DATA_SIZE = 8
) (
  input  logic          clk,
  input  logic          reset,
  systolic_feeder_if.slave bus
);

  typedef enum logic [2:0] {
    StLoad,
    StClear,
    StStream,
    StDrain,
    StDone
  } state_e;

  state_e               state;
  logic [4:0]           load_cnt;
  // Stream step in StStream (0..4), reused as the drain cycle counter
  logic [2:0]           step;

  logic [DATA_SIZE-1:0] mat_a [9];
  logic [DATA_SIZE-1:0] mat_b [9];

  logic [DATA_SIZE-1:0] a_q [3];
  logic [DATA_SIZE-1:0] b_q [3];
  logic [DATA_SIZE-1:0] a_nxt [3];
  logic [DATA_SIZE-1:0] b_nxt [3];

  logic                 pe_clr_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 in_ready_q;

  logic                 accept;
  logic [2:0]           t_sel;

  assign accept = (state == StLoad) && bus.in_valid;

  // Matrix storage; no reset needed since contents are only streamed after a full reload
  always_ff @(posedge clk) begin
    if (accept) begin
      if (load_cnt < 5'd9) begin
        mat_a[load_cnt[3:0]] <= bus.in_data;
      end else begin
        mat_b[4'(load_cnt - 5'd9)] <= bus.in_data;
      end
    end
  end

  // Stream values for the step about to be presented: step 0 when leaving
  // CLEAR, otherwise the step after the current one
  always_comb begin
    t_sel = (state == StClear) ? 3'd0 : step + 3'd1;
    for (int i = 0; i < 3; i++) begin
      a_nxt[i] = '0;
      b_nxt[i] = '0;
      if (int'(t_sel) >= i && int'(t_sel) - i <= 2) begin
        // Row i of A enters i cycles late; column i of B likewise
        a_nxt[i] = mat_a[4'(i * 3 + int'(t_sel) - i)];
        b_nxt[i] = mat_b[4'((int'(t_sel) - i) * 3 + i)];
      end
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= StLoad;
      load_cnt   <= '0;
      step       <= '0;
      pe_clr_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b1;
      for (int i = 0; i < 3; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      pe_clr_q <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
      unique case (state)
        StLoad: begin
          if (bus.in_valid) begin
            if (load_cnt == 5'd17) begin
              state      <= StClear;
              load_cnt   <= '0;
              pe_clr_q   <= 1'b1;
              busy_q     <= 1'b1;
              in_ready_q <= 1'b0;
            end else begin
              load_cnt <= load_cnt + 5'd1;
            end
          end
        end
        StClear: begin
          state <= StStream;
          step  <= '0;
          for (int i = 0; i < 3; i++) begin
            a_q[i] <= a_nxt[i];
            b_q[i] <= b_nxt[i];
          end
        end
        StStream: begin
          if (step == 3'd4) begin
            state <= StDrain;
            step  <= '0;
          end else begin
            step <= step + 3'd1;
            for (int i = 0; i < 3; i++) begin
              a_q[i] <= a_nxt[i];
              b_q[i] <= b_nxt[i];
            end
          end
        end
        StDrain: begin
          if (step == 3'd1) begin
            state  <= StDone;
            step   <= '0;
            done_q <= 1'b1;
          end else begin
            step <= step + 3'd1;
          end
        end
        StDone: begin
          state      <= StLoad;
          load_cnt   <= '0;
          busy_q     <= 1'b0;
          in_ready_q <= 1'b1;
        end
        default: begin
          state      <= StLoad;
          load_cnt   <= '0;
          step       <= '0;
          busy_q     <= 1'b0;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.pe_clr   = pe_clr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.a1       = a_q[0];
  assign bus.a2       = a_q[1];
  assign bus.a3       = a_q[2];
  assign bus.b1       = b_q[0];
  assign bus.b2       = b_q[1];
  assign bus.b3       = b_q[2];

endmodule
